// File: rtl/loop_nest_counter.sv
// Nested loop index generator: NUM_LEVELS counters with per-level runtime bounds,
// level 0 innermost, with start/busy/done handshake, abort, stall and wrap pulses.
module loop_nest_counter #(
    parameter int NUM_LEVELS = 3,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [NUM_LEVELS*WIDTH-1:0]   bound,
    input  logic                          en,
    input  logic                          stop,
    input  logic                          abort,
    output logic [NUM_LEVELS*WIDTH-1:0]   count,
    output logic [NUM_LEVELS-1:0]         wrap,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_run;
    logic                  w_accept;
    logic                  w_cancel;
    logic                  w_step;
    logic                  w_last;
    logic [NUM_LEVELS-1:0] w_at_max;
    logic [NUM_LEVELS:0]   w_carry;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_cancel = w_run && abort;
    assign w_step   = w_run && en && !stop && !abort;

    // w_carry[i] is high when every level below i sits at its last index.
    always_comb begin
        w_carry[0] = 1'b1;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            w_carry[i+1] = w_carry[i] & w_at_max[i];
        end
    end

    assign w_last = w_step && w_carry[NUM_LEVELS];

    generate
        for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : gen_lvl
            logic [WIDTH-1:0] r_lb;
            logic [WIDTH-1:0] r_cnt;
            logic             r_wrap;
            logic [WIDTH-1:0] w_bound_in;

            assign w_bound_in   = bound[gi*WIDTH +: WIDTH];
            assign w_at_max[gi] = (r_cnt == (r_lb - WIDTH'(1)));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_lb   <= '0;
                    r_cnt  <= '0;
                    r_wrap <= 1'b0;
                end else begin
                    // A zero trip count behaves as a single iteration.
                    if (w_accept) begin
                        r_lb <= (w_bound_in == '0) ? WIDTH'(1) : w_bound_in;
                    end
                    if (w_accept || w_cancel) begin
                        r_cnt <= '0;
                    end else if (w_step && w_carry[gi]) begin
                        r_cnt <= w_at_max[gi] ? '0 : (r_cnt + WIDTH'(1));
                    end
                    r_wrap <= w_step && w_carry[gi] && w_at_max[gi];
                end
            end

            assign count[gi*WIDTH +: WIDTH] = r_cnt;
            assign wrap[gi]                 = r_wrap;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort || w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_loop_nest_counter.sv
// Directed bench for loop_nest_counter (3 levels x 8 bits): reset, full nest,
// stall, zero/unit bounds, abort, ignored start, back-to-back jobs.
module tb_loop_nest_counter;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [N*W-1:0] bound;
    logic           en;
    logic           stop;
    logic           abort;
    logic [N*W-1:0] count;
    logic [N-1:0]   wrap;
    logic           busy;
    logic           done;

    int n_vec;
    int n_err;

    loop_nest_counter #(.NUM_LEVELS(N), .WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bound   (bound),
        .en      (en),
        .stop    (stop),
        .abort   (abort),
        .count   (count),
        .wrap    (wrap),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected indices of the {2,3,4} job after k steps (k < 24).
    function automatic logic [N*W-1:0] exp_234(input int k);
        logic [W-1:0] l0, l1, l2;
        l0 = W'(k % 4);
        l1 = W'((k / 4) % 3);
        l2 = W'((k / 12) % 2);
        return {l2, l1, l0};
    endfunction

    task automatic start_job(input logic [N*W-1:0] b);
        bound = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || count !== '0) begin
            n_err++;
            $display("FAIL start_job: busy=%b count=%h required busy=1 count=0", busy, count);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (count !== '0 || wrap !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: count=%h wrap=%b busy=%b done=%b required all 0",
                     count, wrap, busy, done);
        end
        $display("test_reset complete");
    endtask

    task automatic test_full_nest();
        int done_at, ndone, wc0, wc1, wc2;
        done_at = 0; ndone = 0; wc0 = 0; wc1 = 0; wc2 = 0;
        start_job({8'd2, 8'd3, 8'd4});
        en = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (cyc <= 24) begin
                n_vec++;
                if (count !== ((cyc == 24) ? '0 : exp_234(cyc))) begin
                    n_err++;
                    $display("FAIL full_count step %0d: count=%h required %h", cyc, count,
                             (cyc == 24) ? '0 : exp_234(cyc));
                end
            end
            if (wrap[0]) wc0++;
            if (wrap[1]) wc1++;
            if (wrap[2]) wc2++;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = cyc;
                n_vec++;
                if (wrap !== 3'b111) begin
                    n_err++;
                    $display("FAIL full_final_wrap: wrap=%b required 111", wrap);
                end
            end
        end
        en = 1'b0;
        n_vec++;
        if (done_at != 24 || ndone != 1) begin
            n_err++;
            $display("FAIL full_done: at cycle %0d count %0d required at 24 once", done_at, ndone);
        end
        n_vec++;
        if (wc0 != 6 || wc1 != 2 || wc2 != 1) begin
            n_err++;
            $display("FAIL full_wraps: %0d/%0d/%0d required 6/2/1", wc0, wc1, wc2);
        end
        $display("test_full_nest complete: done at %0d", done_at);
    endtask

    task automatic test_stall();
        int cyc;
        bit seen;
        seen = 1'b0;
        cyc = 0;
        start_job({8'd2, 8'd3, 8'd4});
        en = 1'b1;
        repeat (6) tick();
        n_vec++;
        if (count !== {8'd0, 8'd1, 8'd2}) begin
            n_err++;
            $display("FAIL stall_pre: count=%h required 000102", count);
        end
        stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (count !== {8'd0, 8'd1, 8'd2} || wrap !== '0 || done !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold %0d: count=%h wrap=%b done=%b busy=%b required 000102/000/0/1",
                         i, count, wrap, done, busy);
            end
        end
        stop = 1'b0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        en = 1'b0;
        n_vec++;
        if (!seen || (6 + 5 + cyc) != 29) begin
            n_err++;
            $display("FAIL stall_done: seen=%0d total=%0d required seen at 29", seen, 6 + 5 + cyc);
        end
        $display("test_stall complete");
    endtask

    task automatic test_zero_unit();
        start_job({8'd0, 8'd1, 8'd3});
        en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if (count !== {8'd0, 8'd0, W'(k % 3)} || wrap !== ((k == 3) ? 3'b111 : 3'b000)
                || done !== (k == 3)) begin
                n_err++;
                $display("FAIL zero_unit step %0d: count=%h wrap=%b done=%b", k, count, wrap, done);
            end
        end
        tick();
        en = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_unit_after: busy=%b done=%b required 0/0", busy, done);
        end
        $display("test_zero_unit complete");
    endtask

    task automatic test_abort();
        int ndone, nbusy;
        ndone = 0; nbusy = 0;
        start_job({8'd2, 8'd3, 8'd4});
        en = 1'b1;
        repeat (7) tick();
        n_vec++;
        if (count !== exp_234(7)) begin
            n_err++;
            $display("FAIL abort_pre: count=%h required %h", count, exp_234(7));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || count !== '0 || wrap !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: busy=%b count=%h wrap=%b done=%b required all 0",
                     busy, count, wrap, done);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) ndone++;
            if (busy) nbusy++;
        end
        en = 1'b0;
        n_vec++;
        if (ndone != 0 || nbusy != 0) begin
            n_err++;
            $display("FAIL abort_after: done pulses %0d busy cycles %0d required 0/0", ndone, nbusy);
        end
        $display("test_abort complete");
    endtask

    task automatic test_ignored_start();
        int cyc;
        bit seen;
        cyc = 0; seen = 1'b0;
        start_job({8'd2, 8'd3, 8'd4});
        en = 1'b1;
        repeat (3) tick();
        bound = {8'd5, 8'd5, 8'd5};
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (count !== exp_234(4) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ign_start_count: count=%h busy=%b required %h/1", count, busy, exp_234(4));
        end
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        en = 1'b0;
        n_vec++;
        if (!seen || (4 + cyc) != 24) begin
            n_err++;
            $display("FAIL ign_start_done: seen=%0d steps=%0d required 24", seen, 4 + cyc);
        end
        $display("test_ignored_start complete");
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        cyc = 0; seen = 1'b0;
        start_job({8'd2, 8'd3, 8'd4});
        en = 1'b1;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL b2b_first_done: no done within 40 cycles");
        end
        bound = {8'd1, 8'd1, 8'd2};
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || count !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_restart: busy=%b count=%h done=%b required 1/0/0", busy, count, done);
        end
        tick();
        n_vec++;
        if (count !== {8'd0, 8'd0, 8'd1} || done !== 1'b0 || wrap !== '0) begin
            n_err++;
            $display("FAIL b2b_step1: count=%h done=%b wrap=%b required 000001/0/000", count, done, wrap);
        end
        tick();
        en = 1'b0;
        n_vec++;
        if (count !== '0 || done !== 1'b1 || wrap !== 3'b111 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_step2: count=%h done=%b wrap=%b busy=%b required 0/1/111/0",
                     count, done, wrap, busy);
        end
        $display("test_back_to_back complete");
    endtask

    task automatic test_reset_mid_run();
        start_job({8'd2, 8'd3, 8'd4});
        en = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (count !== exp_234(10)) begin
            n_err++;
            $display("FAIL rst_mid_pre: count=%h required %h", count, exp_234(10));
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (count !== '0 || busy !== 1'b0 || wrap !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: count=%h busy=%b wrap=%b done=%b required all 0",
                     count, busy, wrap, done);
        end
        en = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0 || count !== '0) begin
            n_err++;
            $display("FAIL rst_mid_after: busy=%b count=%h required 0/0", busy, count);
        end
        $display("test_reset_mid_run complete");
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        bound   = '0;
        en      = 1'b0;
        stop    = 1'b0;
        abort   = 1'b0;
        #1;
        test_reset();
        #2;
        reset_n = 1'b1;
        tick();
        test_full_nest();
        test_stall();
        test_zero_unit();
        test_abort();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
